int_ctrl: RTL and testbench
===========================

INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter VEC_BASE, default 32'h0000_0100, SHALL be the handler vector of source 0.
REQ-002 Parameter VEC_STRIDE, default 32'h0000_0010, SHALL be the vector spacing between consecutive sources.
REQ-003 in_CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 in_RST  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 in_IRQ  input  4  SHALL carry the external interrupt request lines, one per source (source 3 highest priority).
REQ-006 in_IE  input  1  SHALL carry the CP0 global interrupt-enable bit.
REQ-007 in_INM  input  4  SHALL carry the CP0 interrupt mask: bit i=1 masks source i.
REQ-008 in_STALL  input  1  SHALL indicate the pipeline cannot accept a break this cycle.
REQ-009 in_ERET  input  1  SHALL carry the one-cycle pulse marking return from the handler.
REQ-010 out_BK  output  1  SHALL carry the break strobe to CP0 and the PC mux.
REQ-011 out_NIE  output  1  SHALL carry the IE value CP0 loads on break; constant 0.
REQ-012 out_VEC  output  32  SHALL carry the handler address of the accepted source.
REQ-013 out_ID  output  2  SHALL carry the accepted source number.
REQ-014 out_ACTIVE  output  1  SHALL be 1 while a handler is in service.
REQ-015 out_PEND  output  4  SHALL expose the pending latches.
REQ-016 out_ERET_DONE  output  1  SHALL carry a registered one-cycle pulse telling CP0 to set IE=1.

Function
REQ-017 Each source SHALL have a registered previous-level copy; pend[i] SHALL set on the edge where in_IRQ[i]=1 and its previous level was 0.
REQ-018 A held-high in_IRQ[i] SHALL NOT re-set pend[i] after clearing; only a new rising edge re-pends.
REQ-019 Eligible sources SHALL be pend & ~in_INM, qualified by in_IE=1; the winner SHALL be the highest-index eligible source.
REQ-020 The FSM SHALL have states IDLE, REQ and SERVICE.
REQ-021 IDLE->REQ SHALL occur on the edge where an eligible source exists; the winner SHALL be latched into out_ID at that edge.
REQ-022 A source becoming eligible while in REQ SHALL NOT replace the latched ID.
REQ-023 In REQ, if in_IE=0 or in_INM[out_ID]=1, the FSM SHALL abort to IDLE at the next edge, leave pend unchanged and assert no break.
REQ-024 In REQ with no abort, out_BK SHALL be 1 combinationally when in_STALL=0; REQ SHALL hold, with out_BK=0, while in_STALL=1.
REQ-025 On the edge where out_BK=1, the FSM SHALL enter SERVICE and clear pend[out_ID].
REQ-026 If a new rising edge on the same source coincides with its clear, the set SHALL win.
REQ-027 out_VEC SHALL equal VEC_BASE + out_ID*VEC_STRIDE, truncated to 32 bits, valid whenever the FSM is in REQ or SERVICE.
REQ-028 out_ACTIVE SHALL be 1 exactly in SERVICE; no nesting: pend SHALL keep accumulating, with no new REQ, during SERVICE.
REQ-029 in_ERET in SERVICE SHALL return the FSM to IDLE and pulse out_ERET_DONE for the following cycle; in_ERET in IDLE or REQ SHALL be ignored.
REQ-030 Minimum latency SHALL be: IRQ rise sampled at edge E0 (pend=1), REQ at E1, out_BK=1 in the cycle after E1, SERVICE at E2.
REQ-031 A pending source still eligible after ERET SHALL enter REQ no earlier than the edge after IDLE is re-entered.

Reset
REQ-032 On in_RST=1 the block SHALL asynchronously enter IDLE and set pend=0, the previous-level copies=0, out_ID=0, out_BK=0, out_ACTIVE=0 and out_ERET_DONE=0.
REQ-033 Reset asserted during REQ or SERVICE SHALL discard the request, emit no out_BK, and leave no pending state.
REQ-034 Lines high at reset release SHALL NOT pend until they fall and rise again.

Verification
REQ-035 IE=1, INM=0, IRQ[1] rises before E0 -> out_BK=1 in the cycle after E1, out_ID=1, out_VEC=32'h110, pend[1] clears at E2.
REQ-036 IRQ[0] and IRQ[2] rise together, INM=4'b0100 -> source 0 accepted, out_VEC=32'h100; pend[2] stays 1.
REQ-037 REQ with in_STALL=1 for 3 cycles -> out_BK=0 for 3 cycles, then 1 for exactly one cycle, then SERVICE.
REQ-038 In REQ, IE drops to 0 -> return to IDLE with no out_BK and pend unchanged; IE=1 again -> the request re-enters REQ.
REQ-039 SERVICE on source 3, IRQ[2] rises, then ERET -> out_ERET_DONE is 1 for one cycle, IDLE, then REQ with out_ID=2 and out_VEC=32'h120.
REQ-040 in_RST pulse mid-REQ with IRQ[3] held high -> all outputs 0; after release, no request until IRQ[3] falls and rises.

Source files
------------

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detected pending latches, fixed priority (source 3 highest),
// IDLE/REQ/SERVICE handshake with CP0, no nesting, vectored handler address.
module int_ctrl #(
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic        in_CLK,
  input  logic        in_RST,
  input  logic [3:0]  in_IRQ,
  input  logic        in_IE,
  input  logic [3:0]  in_INM,
  input  logic        in_STALL,
  input  logic        in_ERET,
  output logic        out_BK,
  output logic        out_NIE,
  output logic [31:0] out_VEC,
  output logic [1:0]  out_ID,
  output logic        out_ACTIVE,
  output logic [3:0]  out_PEND,
  output logic        out_ERET_DONE
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t     state;
  logic [3:0] prev;
  logic [3:0] pend;
  logic       armed;
  logic [3:0] rise;
  logic [3:0] eligible;
  logic [3:0] clr;
  logic [1:0] winner;
  logic       any_eligible;
  logic       abort;

  // armed stays low for the first edge after reset so lines already high then
  // only capture their level; they must fall and rise again to pend
  always_comb begin
    rise = '0;
    if (armed) rise = in_IRQ & ~prev;
  end

  always_comb begin
    eligible     = pend & ~in_INM & {4{in_IE}};
    any_eligible = |eligible;
    winner       = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (eligible[i]) winner = 2'(i);
    end
  end

  always_comb begin
    abort  = !in_IE || in_INM[out_ID];
    out_BK = (state == REQ) && !abort && !in_STALL;
    clr    = '0;
    if (out_BK) clr = 4'b0001 << out_ID;
  end

  always_comb begin
    out_VEC = '0;
    if (state != IDLE) out_VEC = VEC_BASE + 32'(out_ID) * VEC_STRIDE;
  end

  assign out_NIE  = 1'b0;
  assign out_PEND = pend;

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      state         <= IDLE;
      prev          <= '0;
      pend          <= '0;
      armed         <= 1'b0;
      out_ID        <= '0;
      out_ACTIVE    <= 1'b0;
      out_ERET_DONE <= 1'b0;
    end else begin
      armed         <= 1'b1;
      prev          <= in_IRQ;
      // a fresh rising edge overrides a simultaneous acceptance clear
      pend          <= (pend & ~clr) | rise;
      out_ERET_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (any_eligible) begin
            state  <= REQ;
            out_ID <= winner;
          end
        end
        REQ: begin
          if (abort) begin
            state <= IDLE;
          end else if (!in_STALL) begin
            state      <= SERVICE;
            out_ACTIVE <= 1'b1;
          end
        end
        SERVICE: begin
          if (in_ERET) begin
            state         <= IDLE;
            out_ACTIVE    <= 1'b0;
            out_ERET_DONE <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Randomized self-checking bench for int_ctrl against a cycle-level behavioural model.
module tb_int_ctrl;

  localparam logic [31:0] VB = 32'h0000_0100;
  localparam logic [31:0] VS = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  irq = '0;
  logic        ie = 1'b0;
  logic [3:0]  inm = '0;
  logic        stall = 1'b0;
  logic        eret = 1'b0;
  logic        bk, nie, active, eret_done;
  logic [31:0] vec;
  logic [1:0]  id;
  logic [3:0]  pend;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  bit [3:0] m_prev, m_pend;
  bit       m_armed, m_req, m_srv, m_done;
  int       m_id;

  int_ctrl #(.VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
    .in_CLK(clk), .in_RST(rst), .in_IRQ(irq), .in_IE(ie), .in_INM(inm),
    .in_STALL(stall), .in_ERET(eret), .out_BK(bk), .out_NIE(nie), .out_VEC(vec),
    .out_ID(id), .out_ACTIVE(active), .out_PEND(pend), .out_ERET_DONE(eret_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_prev = '0; m_pend = '0; m_armed = 0; m_req = 0; m_srv = 0; m_done = 0; m_id = 0;
  endfunction

  function automatic bit m_abort();
    return !ie || inm[m_id];
  endfunction

  function automatic bit m_bk();
    return m_req && !m_abort() && !stall;
  endfunction

  task automatic compare_all();
    logic [31:0] ev;
    ev = (m_req || m_srv) ? VB + 32'(m_id) * VS : 32'h0;
    check_eq("bk", 32'(bk), 32'(m_bk()));
    check_eq("id", 32'(id), 32'(m_id));
    check_eq("vec", vec, ev);
    check_eq("active", 32'(active), 32'(m_srv));
    check_eq("pend", 32'(pend), 32'(m_pend));
    check_eq("eret_done", 32'(eret_done), 32'(m_done));
    check_eq("nie", 32'(nie), 32'h0);
  endtask

  // one clock edge of the specified behaviour, using the inputs currently applied
  function automatic void model_step();
    bit [3:0] np;
    bit       bkv, found;
    int       win;
    bkv = m_bk();
    found = 0; win = 0;
    for (int i = 3; i >= 0; i--) begin
      if (!found && m_pend[i] && !inm[i] && ie) begin
        found = 1; win = i;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (m_armed && irq[i] && !m_prev[i]) np[i] = 1;
      else if (bkv && i == m_id) np[i] = 0;
      else np[i] = m_pend[i];
    end
    m_done = 0;
    if (!m_req && !m_srv) begin
      if (found) begin m_req = 1; m_id = win; end
    end else if (m_req) begin
      if (m_abort()) m_req = 0;
      else if (!stall) begin m_req = 0; m_srv = 1; end
    end else if (m_srv && eret) begin
      m_srv = 0; m_done = 1;
    end
    m_pend = np; m_prev = irq; m_armed = 1;
  endfunction

  task automatic cycle(input logic [3:0] i_irq, input logic i_ie, input logic [3:0] i_inm,
                       input logic i_stall, input logic i_eret);
    @(posedge clk); #1;
    irq = i_irq; ie = i_ie; inm = i_inm; stall = i_stall; eret = i_eret;
    @(negedge clk);
    compare_all();
    model_step();
  endtask

  task automatic do_reset(input logic [3:0] i_irq);
    @(posedge clk); #1;
    irq = i_irq; eret = 1'b0; stall = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_bk", 32'(bk), 32'h0);
    check_eq("rst_active", 32'(active), 32'h0);
    check_eq("rst_pend", 32'(pend), 32'h0);
    check_eq("rst_id", 32'(id), 32'h0);
    check_eq("rst_done", 32'(eret_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    compare_all();
    model_step();
  endtask

  initial begin
    model_reset();
    // source 1 alone: minimum latency path and vector
    do_reset(4'h0);
    cycle(4'h0, 1, 4'h0, 0, 0);
    cycle(4'h2, 1, 4'h0, 0, 0);
    cycle(4'h2, 1, 4'h0, 0, 0);
    cycle(4'h2, 1, 4'h0, 0, 0);
    check_eq("d1_bk", 32'(bk), 32'h1);
    check_eq("d1_id", 32'(id), 32'h1);
    check_eq("d1_vec", vec, 32'h110);
    cycle(4'h2, 1, 4'h0, 0, 0);
    check_eq("d1_active", 32'(active), 32'h1);
    check_eq("d1_pend", 32'(pend), 32'h0);
    cycle(4'h2, 1, 4'h0, 0, 1);
    cycle(4'h0, 1, 4'h0, 0, 0);
    check_eq("d1_done", 32'(eret_done), 32'h1);

    // sources 0 and 2 together with 2 masked
    do_reset(4'h0);
    cycle(4'h0, 1, 4'h4, 0, 0);
    cycle(4'h5, 1, 4'h4, 0, 0);
    cycle(4'h5, 1, 4'h4, 0, 0);
    cycle(4'h5, 1, 4'h4, 0, 0);
    check_eq("d2_id", 32'(id), 32'h0);
    check_eq("d2_vec", vec, 32'h100);
    cycle(4'h5, 1, 4'h4, 0, 0);
    check_eq("d2_pend", 32'(pend), 32'h4);

    // reset mid-REQ with source 3 held high, then needs a fresh rise
    do_reset(4'h0);
    cycle(4'h0, 1, 4'h0, 0, 0);
    cycle(4'h8, 1, 4'h0, 1, 0);
    cycle(4'h8, 1, 4'h0, 1, 0);
    cycle(4'h8, 1, 4'h0, 1, 0);
    do_reset(4'h8);
    for (int k = 0; k < 4; k++) cycle(4'h8, 1, 4'h0, 0, 0);
    check_eq("d3_nopend", 32'(pend), 32'h0);
    cycle(4'h0, 1, 4'h0, 0, 0);
    cycle(4'h8, 1, 4'h0, 0, 0);
    cycle(4'h8, 1, 4'h0, 0, 0);
    check_eq("d3_repend", 32'(pend), 32'h8);

    // randomized phase
    do_reset(4'h0);
    for (int n = 0; n < 4000; n++) begin
      logic [3:0] r_irq, r_inm;
      logic r_ie, r_stall, r_eret;
      if ($urandom_range(0, 299) == 0) begin
        do_reset(4'($urandom));
      end else begin
        r_irq = irq;
        for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) r_irq[b] = ~r_irq[b];
        r_ie    = ($urandom_range(0, 7) != 0);
        r_inm   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        r_stall = ($urandom_range(0, 2) == 0);
        r_eret  = m_srv ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
        cycle(r_irq, r_ie, r_inm, r_stall, r_eret);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
